// File: rtl/dsp_config_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : dsp_config_loader_if
// Brief    : Valid/ready word stream from a bitstream source into the loader.
// Revision : 1.0
// ============================================================================
interface dsp_config_loader_if #(
  parameter int WORD_W = 32
) ();
  logic [WORD_W-1:0] cfg_word;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_word, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_word, input cfg_valid, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/dsp_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : dsp_config_loader
// Brief    : Serializes configuration words LSB-first onto a DSP shift chain.
// Revision : 1.0
// ============================================================================
module dsp_config_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             start,
  input  wire logic             abort,
  dsp_config_loader_if.slave    cfg,
  output logic                  configuration_input,
  output logic                  configuration_enable,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bit_count
);

  localparam int c_NW     = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int c_LAST   = CHAIN_LEN - (c_NW - 1) * WORD_W;
  localparam int c_WACC_W = $clog2(c_NW + 1);
  localparam int c_LEFT_W = $clog2(WORD_W + 1);

  localparam logic [c_WACC_W-1:0] c_NW_V      = c_WACC_W'(c_NW);
  localparam logic [c_WACC_W-1:0] c_NW_M1     = c_WACC_W'(c_NW - 1);
  localparam logic [c_WACC_W-1:0] c_WACC_ONE  = c_WACC_W'(1);
  localparam logic [c_LEFT_W-1:0] c_FULL_LEFT = c_LEFT_W'(WORD_W);
  localparam logic [c_LEFT_W-1:0] c_LAST_LEFT = c_LEFT_W'(c_LAST);
  localparam logic [c_LEFT_W-1:0] c_LEFT_ONE  = c_LEFT_W'(1);
  localparam logic [CNT_W-1:0]    c_CHAIN     = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_hold;
  logic                r_hold_full;
  logic [WORD_W-1:0]   r_sh;
  logic [c_LEFT_W-1:0] r_sh_left;
  logic [c_WACC_W-1:0] r_wacc;
  logic [c_WACC_W-1:0] r_wsh;
  logic                r_cfg_in;
  logic                r_cfg_en;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_bit_count;

  logic                w_cfg_ready;
  logic                w_accept;
  logic                w_shift;
  logic                w_refill;
  logic [c_LEFT_W-1:0] w_refill_len;

  assign w_cfg_ready  = r_busy & ~r_hold_full & (r_wacc < c_NW_V) & ~abort;
  assign w_accept     = cfg.cfg_valid & w_cfg_ready;
  assign w_shift      = (r_sh_left != '0);
  // Refill on the edge the shifter empties so a waiting word streams gaplessly
  assign w_refill     = r_hold_full & ((r_sh_left == '0) | (r_sh_left == c_LEFT_ONE));
  assign w_refill_len = (r_wsh == c_NW_M1) ? c_LAST_LEFT : c_FULL_LEFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_sh        <= '0;
      r_sh_left   <= '0;
      r_wacc      <= '0;
      r_wsh       <= '0;
      r_cfg_in    <= 1'b0;
      r_cfg_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bit_count <= '0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_hold_full <= 1'b0;
      r_sh_left   <= '0;
      r_cfg_in    <= 1'b0;
      r_cfg_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_cfg_in <= 1'b0;
      r_cfg_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_wacc      <= '0;
            r_wsh       <= '0;
            r_bit_count <= '0;
            r_hold_full <= 1'b0;
            r_sh_left   <= '0;
          end
        end
        S_RUN: begin
          if (r_bit_count == c_CHAIN) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            if (w_shift) begin
              r_cfg_in    <= r_sh[0];
              r_cfg_en    <= 1'b1;
              r_sh        <= r_sh >> 1;
              r_sh_left   <= r_sh_left - c_LEFT_ONE;
              r_bit_count <= r_bit_count + c_CNT_ONE;
            end
            if (w_refill) begin
              r_sh        <= r_hold;
              r_sh_left   <= w_refill_len;
              r_hold_full <= 1'b0;
              r_wsh       <= r_wsh + c_WACC_ONE;
            end
            if (w_accept) begin
              r_hold      <= cfg.cfg_word;
              r_hold_full <= 1'b1;
              r_wacc      <= r_wacc + c_WACC_ONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg.cfg_ready          = w_cfg_ready;
  assign configuration_input    = r_cfg_in;
  assign configuration_enable   = r_cfg_en;
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign bit_count              = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_dsp_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_config_loader
// Brief    : Bench for dsp_config_loader with 64-bit and 40-bit chain instances.
// Revision : 1.0
// ============================================================================
module tb_dsp_config_loader;
  localparam int WW = 32;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start [2];
  logic          abort [2];
  logic [WW-1:0] word  [2];
  logic          valid [2];
  logic          ready [2];
  logic          cin   [2];
  logic          cen   [2];
  logic          busy  [2];
  logic          done  [2];
  logic [6:0]    bc64;
  logic [5:0]    bc40;

  dsp_config_loader_if #(.WORD_W(WW)) if64 ();
  dsp_config_loader_if #(.WORD_W(WW)) if40 ();

  assign if64.cfg_word  = word[0];
  assign if64.cfg_valid = valid[0];
  assign ready[0]       = if64.cfg_ready;
  assign if40.cfg_word  = word[1];
  assign if40.cfg_valid = valid[1];
  assign ready[1]       = if40.cfg_ready;

  dsp_config_loader #(.CHAIN_LEN(64), .WORD_W(WW)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .cfg(if64.slave),
    .configuration_input(cin[0]), .configuration_enable(cen[0]),
    .busy(busy[0]), .done(done[0]), .bit_count(bc64)
  );

  dsp_config_loader #(.CHAIN_LEN(40), .WORD_W(WW)) u_dut40 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .cfg(if40.slave),
    .configuration_input(cin[1]), .configuration_enable(cen[1]),
    .busy(busy[1]), .done(done[1]), .bit_count(bc40)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;
  always @(posedge clk) t <= t + 1;

  // Model: each accepted word owns a contiguous window of enable cycles that
  // opens at max(accept edge + 2, previous window end + 1).
  int            nacc      [2];
  int            acc_e     [2][4];
  int            st        [2][4];
  int            ln        [2][4];
  logic [WW-1:0] wd        [2][4];
  bit            active    [2];
  int            bits      [2];
  int            done_edge [2];

  int            en_cnt    [2];
  int            done_cnt  [2];
  int            last_en   [2];
  int            max_gap   [2];
  logic [63:0]   cap       [2];

  function automatic void chk(input string nm, input int d, input logic [63:0] got,
                              input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0d: got %0h, expected %0h", nm, d, t, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit          e_en, e_in, e_busy, e_done, e_rdy, occ;
      int          e_bits, b, last_end, k, pe;
      logic [63:0] got_bc;
      e_en = 0; e_in = 0; e_busy = 0; e_done = 0; occ = 0;
      e_bits = bits[d];
      if (!rst_n) begin
        active[d] = 0; nacc[d] = 0; bits[d] = 0; e_bits = 0; done_edge[d] = -10;
      end else if (active[d]) begin
        e_bits   = 0;
        last_end = 1 << 30;
        for (int j = 0; j < nacc[d]; j++) begin
          if (t >= st[d][j] && t < st[d][j] + ln[d][j]) begin
            e_en = 1;
            e_in = wd[d][j][t - st[d][j]];
          end
          b = t - st[d][j] + 1;
          if (b < 0) b = 0;
          if (b > ln[d][j]) b = ln[d][j];
          e_bits += b;
          if (t >= acc_e[d][j] && t <= st[d][j] - 2) occ = 1;
        end
        if (nacc[d] == NW) last_end = st[d][NW-1] + ln[d][NW-1] - 1;
        if (t == last_end + 1) begin
          e_done = 1; active[d] = 0; done_edge[d] = t;
        end else begin
          e_busy = 1;
        end
        bits[d] = e_bits;
      end
      e_rdy = e_busy && !occ && (nacc[d] < NW) && !abort[d];

      if (cen[d] === 1'b1) begin
        cap[d] = {cin[d], cap[d][63:1]};
        if (last_en[d] >= 0 && t - last_en[d] - 1 > max_gap[d]) max_gap[d] = t - last_en[d] - 1;
        last_en[d] = t;
        en_cnt[d]++;
      end
      if (done[d] === 1'b1) done_cnt[d]++;

      got_bc = (d == 0) ? 64'(bc64) : 64'(bc40);
      chk("enable",    d, 64'(cen[d]),   64'(e_en));
      chk("data",      d, 64'(cin[d]),   64'(e_in));
      chk("busy",      d, 64'(busy[d]),  64'(e_busy));
      chk("done",      d, 64'(done[d]),  64'(e_done));
      chk("cfg_ready", d, 64'(ready[d]), 64'(e_rdy));
      chk("bit_count", d, got_bc,        64'(e_bits));

      if (rst_n) begin
        if (abort[d]) begin
          active[d] = 0;
        end else if (!active[d] && start[d] && t != done_edge[d]) begin
          active[d] = 1; nacc[d] = 0; bits[d] = 0;
        end else if (active[d] && valid[d] && e_rdy) begin
          k = nacc[d];
          acc_e[d][k] = t + 1;
          ln[d][k]    = (k == NW - 1) ? ((d == 0) ? 32 : 8) : WW;
          wd[d][k]    = word[d];
          pe          = (k == 0) ? -100 : st[d][k-1] + ln[d][k-1] - 1;
          st[d][k]    = (t + 3 > pe + 1) ? t + 3 : pe + 1;
          nacc[d]     = k + 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_cap(input int d);
    en_cnt[d] = 0; done_cnt[d] = 0; last_en[d] = -1; max_gap[d] = 0; cap[d] = '0;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    tick(1);
    start[d] = 1'b0;
  endtask

  task automatic send_word(input int d, input logic [WW-1:0] w);
    bit ok;
    ok = 0;
    word[d]  = w;
    valid[d] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      ok = ready[d];
      tick(1);
      if (ok) break;
    end
    valid[d] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept dut%0d word %0h: accepted 0, required 1", d, w);
    end
  endtask

  task automatic wait_bits(input int d, input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      if (en_cnt[d] >= n) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_bits dut%0d: got %0d enables, required %0d", d, en_cnt[d], n);
    end
  endtask

  task automatic wait_done(input int d);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      if (done[d] === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_done dut%0d: done 0, required 1", d);
    end
  endtask

  task automatic full_load64(input logic [WW-1:0] w1, input logic [WW-1:0] w2);
    clear_cap(0);
    pulse_start(0);
    send_word(0, w1);
    send_word(0, w2);
    wait_done(0);
    tick(3);
    chk("load enables", 0, 64'(en_cnt[0]),   64'd64);
    chk("load gap",     0, 64'(max_gap[0]),  64'd0);
    chk("load stream",  0, cap[0],           {w2, w1});
    chk("load dones",   0, 64'(done_cnt[0]), 64'd1);
    chk("load count",   0, 64'(bc64),        64'd64);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; abort[d] = 1'b0; valid[d] = 1'b0; word[d] = '0;
      clear_cap(d);
    end
    #1 rst_n = 1'b0;
    tick(2);

    // Reset state, then cfg_valid in IDLE must be ignored
    for (int d = 0; d < 2; d++) begin
      chk("rst enable", d, 64'(cen[d]),   64'd0);
      chk("rst busy",   d, 64'(busy[d]),  64'd0);
      chk("rst ready",  d, 64'(ready[d]), 64'd0);
    end
    chk("rst count", 0, 64'(bc64), 64'd0);
    word[0]  = 32'hCAFEF00D;
    valid[0] = 1'b1;
    rst_n    = 1'b1;
    tick(4);
    chk("idle ready", 0, 64'(ready[0]), 64'd0);
    chk("idle busy",  0, 64'(busy[0]),  64'd0);
    valid[0] = 1'b0;
    tick(2);

    // Back-to-back load
    full_load64(32'h0F0FA5A5, 32'h12345678);

    // Partial last word on the 40-bit chain
    clear_cap(1);
    pulse_start(1);
    send_word(1, 32'hFFFFFFFF);
    send_word(1, 32'hABCDEF5A);
    chk("partial ready after last", 1, 64'(ready[1]), 64'd0);
    wait_done(1);
    tick(3);
    chk("partial enables", 1, 64'(en_cnt[1]),      64'd40);
    chk("partial tail",    1, 64'(cap[1][63:56]),  64'h5A);
    chk("partial head",    1, 64'(cap[1][55:24]),  64'hFFFFFFFF);
    chk("partial count",   1, 64'(bc40),           64'd40);
    chk("partial dones",   1, 64'(done_cnt[1]),    64'd1);

    // Starvation: second word accepted four edges after the first word's last bit
    clear_cap(0);
    pulse_start(0);
    send_word(0, 32'h0F0FA5A5);
    wait_bits(0, 32);
    tick(3);
    send_word(0, 32'h12345678);
    wait_done(0);
    tick(3);
    chk("starve enables", 0, 64'(en_cnt[0]),   64'd64);
    chk("starve gap",     0, 64'(max_gap[0]),  64'd5);
    chk("starve stream",  0, cap[0],           64'h12345678_0F0FA5A5);
    chk("starve dones",   0, 64'(done_cnt[0]), 64'd1);

    // Abort mid-load, then a clean reload
    clear_cap(0);
    pulse_start(0);
    send_word(0, 32'h13579BDF);
    send_word(0, 32'h2468ACE0);
    wait_bits(0, 20);
    tick(1);
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    @(negedge clk); #1;
    chk("abort enable", 0, 64'(cen[0]),  64'd0);
    chk("abort busy",   0, 64'(busy[0]), 64'd0);
    chk("abort count",  0, 64'(bc64),    64'd21);
    tick(5);
    chk("abort dones",  0, 64'(done_cnt[0]), 64'd0);
    full_load64(32'hDEADBEEF, 32'hC001D00D);

    // Start while busy is ignored
    clear_cap(0);
    pulse_start(0);
    send_word(0, 32'h89ABCDEF);
    wait_bits(0, 10);
    tick(1);
    pulse_start(0);
    send_word(0, 32'h76543210);
    wait_done(0);
    tick(6);
    chk("busy-start dones",   0, 64'(done_cnt[0]), 64'd1);
    chk("busy-start enables", 0, 64'(en_cnt[0]),   64'd64);
    chk("busy-start stream",  0, cap[0],           64'h76543210_89ABCDEF);

    // Asynchronous reset in the middle of a load
    clear_cap(0);
    pulse_start(0);
    send_word(0, 32'h5555AAAA);
    wait_bits(0, 5);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async rst enable", 0, 64'(cen[0]),   64'd0);
    chk("async rst busy",   0, 64'(busy[0]),  64'd0);
    chk("async rst count",  0, 64'(bc64),     64'd0);
    chk("async rst ready",  0, 64'(ready[0]), 64'd0);
    tick(2);
    rst_n    = 1'b1;
    word[0]  = 32'h0BADC0DE;
    valid[0] = 1'b1;
    tick(3);
    chk("post rst ready", 0, 64'(ready[0]), 64'd0);
    chk("post rst busy",  0, 64'(busy[0]),  64'd0);
    valid[0] = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
